// File: rtl/alu_share_if.sv
// Request/response bundle between two ALU requesters and the shared-ALU arbiter.
// Requester i occupies bit i of each 2-bit field and slice i of each packed field.
interface alu_share_if #(
    parameter int unsigned N = 32
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [7:0]     req_ctrl;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic [1:0]     req_cin;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [2*N-1:0] rsp_res;
    logic [1:0]     rsp_cout;
    logic [1:0]     rsp_cmp;

    modport master (
        output req_valid, req_ctrl, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_cout, rsp_cmp
    );

    modport slave (
        input  req_valid, req_ctrl, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_cout, rsp_cmp
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter time-sharing one integer ALU between two requesters.
// Each requester owns a one-entry result slot; a grant loads the slot one cycle later.
module alu_share_arbiter #(
    parameter int unsigned N = 32
) (
    input logic        clk,
    input logic        rst,
    alu_share_if.slave bus
);

    logic [1:0]        elig;
    logic [1:0]        grant;
    logic              sel;
    logic              rr_ptr;

    logic [3:0]        op;
    logic [N-1:0]      opa;
    logic [N-1:0]      opb;
    logic              cin;
    logic [N:0]        sum;
    logic [N-1:0]      res;
    logic              cout;
    logic              cmp;

    logic [1:0]        valid_q;
    logic [1:0][N-1:0] res_q;
    logic [1:0]        cout_q;
    logic [1:0]        cmp_q;

    // Grant: a requester may issue if its slot is free or being drained this cycle.
    // Depends only on valids, rsp_ready and slot state, never on operands.
    always_comb begin
        elig  = bus.req_valid & (~valid_q | bus.rsp_ready);
        grant = 2'b00;
        if (!rst) begin
            unique case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel = grant[1];

    // Operand mux for the granted requester.
    always_comb begin
        op  = sel ? bus.req_ctrl[7:4]  : bus.req_ctrl[3:0];
        opa = sel ? bus.req_a[2*N-1:N] : bus.req_a[N-1:0];
        opb = sel ? bus.req_b[2*N-1:N] : bus.req_b[N-1:0];
        cin = sel ? bus.req_cin[1]     : bus.req_cin[0];
    end

    // Shared ALU; fields an op does not produce stay zero.
    // Shifts take the whole B operand, so B >= N saturates naturally.
    always_comb begin
        sum  = '0;
        res  = '0;
        cout = 1'b0;
        cmp  = 1'b0;
        case (op)
            4'b0000: begin
                sum  = {1'b0, opa} + {1'b0, opb} + {{N{1'b0}}, cin};
                res  = sum[N-1:0];
                cout = sum[N];
            end
            4'b0001: res = opa - opb;
            4'b0010: res = opa | opb;
            4'b0011: res = opa ^ opb;
            4'b0100: res = opa & opb;
            4'b0101: res = opa >> opb;
            4'b0110: res = $unsigned($signed(opa) >>> opb);
            4'b0111: res = opa << opb;
            4'b1000: cmp = (opa < opb);
            default: cmp = ($signed(opa) < $signed(opb));
        endcase
    end

    // Result slots: accept loads new data, consume-only clears valid and keeps data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 2'b00;
            res_q   <= '0;
            cout_q  <= 2'b00;
            cmp_q   <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    valid_q[i] <= 1'b1;
                    res_q[i]   <= res;
                    cout_q[i]  <= cout;
                    cmp_q[i]   <= cmp;
                end else if (valid_q[i] && bus.rsp_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer: after any grant, prefer the requester that lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (grant != 2'b00) begin
            rr_ptr <= grant[0];
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_res   = res_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_cmp   = cmp_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter at N=8: ALU vector table, hand-written arbitration
// sequences, and a randomized run against a behavioural model.
module tb_alu_share_arbiter;

    localparam int unsigned N = 8;

    logic clk;
    logic rst;

    alu_share_if #(.N(N)) bus ();

    alu_share_arbiter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] ctrl;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic       cout;
        logic       cmp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from plain integer arithmetic.
    function automatic void ref_alu(input int unsigned op, input int unsigned a,
                                    input int unsigned b, input int unsigned ci,
                                    output int unsigned res, output int unsigned co,
                                    output int unsigned cm);
        int sa;
        int sb;
        int unsigned s;
        sa  = (a >= 128) ? int'(a) - 256 : int'(a);
        sb  = (b >= 128) ? int'(b) - 256 : int'(b);
        res = 0;
        co  = 0;
        cm  = 0;
        case (op)
            0: begin s = a + b + ci; res = s % 256; co = s / 256; end
            1: res = (a + 256 - b) % 256;
            2: res = a | b;
            3: res = a ^ b;
            4: res = a & b;
            5: res = (b >= 8) ? 0 : a / (2 ** b);
            6: begin
                for (int k = 0; k < 8 && k < int'(b); k++) sa = (sa - (sa & 1)) / 2;
                res = int'(sa) & 255;
            end
            7: res = (b >= 8) ? 0 : (a * (2 ** b)) % 256;
            8: cm = (a < b) ? 1 : 0;
            default: cm = (sa < sb) ? 1 : 0;
        endcase
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Randomized-run model state.
    int unsigned pctrl[2], pa[2], pb[2], pcin[2];
    bit          pend[2];
    bit          mv[2];
    int unsigned mres[2], mcout[2], mcmp[2];
    int          pref;

    initial begin
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_ctrl  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = 2'b00;

        vecs[0]  = '{4'h0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[1]  = '{4'h1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
        vecs[2]  = '{4'h2, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[3]  = '{4'h3, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0, 1'b0};
        vecs[4]  = '{4'h4, 8'hAA, 8'h0F, 1'b1, 8'h0A, 1'b0, 1'b0};
        vecs[5]  = '{4'h6, 8'h90, 8'h02, 1'b0, 8'hE4, 1'b0, 1'b0};
        vecs[6]  = '{4'h5, 8'h90, 8'h09, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{4'h7, 8'h81, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0};
        vecs[8]  = '{4'h8, 8'h80, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{4'h9, 8'h80, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{4'hF, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{4'h6, 8'h80, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[12] = '{4'h1, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b0, 1'b0};
        vecs[13] = '{4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[14] = '{4'h8, 8'h01, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1};

        // Reset held two cycles with both requesters valid.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_ready", 32'(bus.req_ready), 32'h0);
            chk("rst_rsp", {bus.rsp_valid, bus.rsp_cout, bus.rsp_cmp, bus.rsp_res}, 32'h0);
        end
        rst = 1'b0;
        #1 chk("rst_release_ready", 32'(bus.req_ready), 32'h1);

        // ALU vector table on requester 0.
        reset_dut();
        foreach (vecs[i]) begin
            bus.req_valid = 2'b01;
            bus.rsp_ready = 2'b11;
            bus.req_ctrl  = {4'h0, vecs[i].ctrl};
            bus.req_a     = {8'h00, vecs[i].a};
            bus.req_b     = {8'h00, vecs[i].b};
            bus.req_cin   = {1'b0, vecs[i].cin};
            #1 chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out", i),
                {bus.rsp_valid, bus.rsp_cout[0], bus.rsp_cmp[0], bus.rsp_res[7:0]},
                {2'b01, vecs[i].cout, vecs[i].cmp, vecs[i].res});
            @(negedge clk);
        end

        // Contention: grants alternate, r1 slt gives cmp=1, r0 sltu gives cmp=0.
        reset_dut();
        begin
            logic [1:0] g;
            g = 2'b01;
            for (int k = 0; k < 6; k++) begin
                bus.req_valid = 2'b11;
                bus.rsp_ready = 2'b11;
                bus.req_ctrl  = 8'h98;
                bus.req_a     = 16'h8080;
                bus.req_b     = 16'h0101;
                bus.req_cin   = 2'b00;
                #1 chk("cont_ready", 32'(bus.req_ready), 32'(g));
                @(posedge clk);
                #1 chk("cont_valid", 32'(bus.rsp_valid), 32'(g));
                if (g == 2'b01) chk("cont_r0", {bus.rsp_cmp[0], bus.rsp_res[7:0]}, 32'h0);
                else chk("cont_r1", {bus.rsp_cmp[1], bus.rsp_res[15:8]}, 32'h100);
                g = {g[0], g[1]};
                @(negedge clk);
            end
        end

        // Backpressure: slot 0 stuck full, r1 served each cycle, then r0 refilled.
        reset_dut();
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b00;
        bus.req_ctrl  = 8'h22;
        bus.req_a     = 16'h0311;
        bus.req_b     = 16'h0422;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 2'b11;
            bus.rsp_ready = 2'b10;
            bus.req_a     = {8'(k), 8'h11};
            #1 chk("bp_ready", 32'(bus.req_ready), 32'h2);
            @(posedge clk);
            #1 chk("bp_out", {bus.rsp_valid, bus.rsp_res}, {2'b11, 8'(k) | 8'h04, 8'h33});
            @(negedge clk);
        end
        bus.rsp_ready = 2'b11;
        bus.req_ctrl  = 8'h24;
        bus.req_a     = 16'h03F0;
        bus.req_b     = 16'h043C;
        #1 chk("bp_release_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1 chk("bp_release_out", {bus.rsp_valid, bus.rsp_res[7:0]}, {2'b01, 8'h30});
        @(negedge clk);

        // Reset mid-operation discards slot and rr_ptr.
        reset_dut();
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b00;
        bus.req_ctrl  = 8'h02;
        bus.req_a     = 16'h00A5;
        bus.req_b     = 16'h0000;
        @(negedge clk);
        chk("mid_full", {bus.rsp_valid, bus.rsp_res[7:0]}, {2'b01, 8'hA5});
        rst = 1'b1;
        bus.req_valid = 2'b11;
        #1 chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1 chk("mid_rst_out", {bus.rsp_valid, bus.rsp_res}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 2'b11;
        #1 chk("mid_after_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);

        // Randomized traffic against the model.
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; mv[i] = 0; mres[i] = 0; mcout[i] = 0; mcmp[i] = 0;
        end
        pref = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            logic [1:0] rr;
            bit el[2];
            int win;
            logic [1:0] exp_g;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom % 4 != 0)) begin
                    pend[i]  = 1;
                    pctrl[i] = $urandom_range(0, 15);
                    pa[i]    = $urandom_range(0, 255);
                    pb[i]    = ($urandom % 2 == 0) ? $urandom_range(0, 10) : $urandom_range(0, 255);
                    pcin[i]  = $urandom_range(0, 1);
                end
            end
            rr = 2'($urandom_range(0, 3));
            if ($urandom % 2 == 0) rr = 2'b11;
            bus.req_valid = {pend[1], pend[0]};
            bus.rsp_ready = rr;
            bus.req_ctrl  = {4'(pctrl[1]), 4'(pctrl[0])};
            bus.req_a     = {8'(pa[1]), 8'(pa[0])};
            bus.req_b     = {8'(pb[1]), 8'(pb[0])};
            bus.req_cin   = {1'(pcin[1]), 1'(pcin[0])};
            #1;
            chk("rnd_rsp", {bus.rsp_valid, bus.rsp_cout, bus.rsp_cmp, bus.rsp_res},
                {1'(mv[1]), 1'(mv[0]), 1'(mcout[1]), 1'(mcout[0]), 1'(mcmp[1]), 1'(mcmp[0]),
                 8'(mres[1]), 8'(mres[0])});
            for (int i = 0; i < 2; i++) el[i] = pend[i] && (!mv[i] || rr[i]);
            if (el[0] && el[1]) win = pref;
            else if (el[0]) win = 0;
            else if (el[1]) win = 1;
            else win = -1;
            exp_g = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
            chk("rnd_ready", 32'(bus.req_ready), 32'(exp_g));
            for (int i = 0; i < 2; i++) begin
                if (win == i) begin
                    ref_alu(pctrl[i], pa[i], pb[i], pcin[i], mres[i], mcout[i], mcmp[i]);
                    mv[i]   = 1;
                    pend[i] = 0;
                end else if (mv[i] && rr[i]) begin
                    mv[i] = 0;
                end
            end
            if (win >= 0) pref = 1 - win;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter that time-shares one integer ALU (add/sub/or/xor/and/srl/sra/sll/sltu/slt, 4-bit op code) in the RISC-V core. Each requester has a valid/ready request channel and a valid/ready response channel. The arbiter grants round-robin, evaluates the ALU combinationally on the granted operands, and captures Res/Cout/Cmp into a one-entry result slot per requester. Typical requesters are the execute stage and the branch/address unit.

## Interface
- N, 32, operand/result width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  2  request valid; bit i = requester i
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- req_ctrl  in  8  op code; requester i uses bits [4i+3:4i]
- req_a  in  2N  operand A; requester i uses bits [N*i+N-1:N*i]
- req_b  in  2N  operand B, same packing
- req_cin  in  2  carry-in, used by add only
- rsp_valid  out  2  result slot i holds a result
- rsp_ready  in  2  requester i consumes its result
- rsp_res  out  2N  result, same packing
- rsp_cout  out  2  carry-out (add only, else 0)
- rsp_cmp  out  2  compare flag (sltu/slt only, else 0)

## Operation
- Op codes: 0000 add with cin, {cout,res}=A+B+cin; 0001 sub A-B, cin ignored; 0010 or; 0011 xor; 0100 and; 0101 srl A>>B; 0110 sra, signed A>>>B; 0111 sll A<<B; 1000 sltu, cmp=(A<B) unsigned; 1001 and 1010-1111 slt, cmp=signed(A)<signed(B).
- Shifts use the full B value. Any B ≥ N gives 0 for srl/sll, and all sign bits for sra.
- Fields not produced by an op are 0: compare ops give res=0; non-add ops give cout=0; non-compare ops give cmp=0.
- Eligibility: requester i is eligible when req_valid[i]=1 and (slot i is empty, or rsp_valid[i] & rsp_ready[i]).
- Grant: one eligible requester goes alone. Two eligible requesters: the one selected by rr_ptr wins. No eligible requester: no grant.
- req_ready = grant, combinational from req_valid, rsp_ready and slot state. No combinational path from req_ctrl, req_a or req_b to any ready.
- rr_ptr updates only on a grant: rr_ptr ← index of the non-granted requester.
- Slot i on the clock edge:
  - accept into i: load the ALU outputs and set rsp_valid[i]=1;
  - consume only (rsp_valid[i]&rsp_ready[i], no accept): clear rsp_valid[i], data held;
  - consume and accept together: slot stays valid and holds the new data.
- The non-granted requester must keep req_valid and its operands stable until accepted. The arbiter does not check this.
- Starvation bound: with both requesters continuously eligible, each waits at most 1 cycle.

## Timing
- Request accept to rsp_valid: 1 cycle, registered.
- Throughput: 1 op/cycle total across both requesters. Requester i can issue every cycle when it is alone and consumes each result the cycle it appears.
- Reset values: rsp_valid=00, rsp_res=0, rsp_cout=00, rsp_cmp=00, rr_ptr=0 (requester 0 preferred).
- req_ready=00 combinationally whenever rst=1.
- Reset mid-operation: pending slot contents are discarded. rsp_valid=00 on the cycle after the rst edge, with no output glitch to stale data.
- rsp_ready with rsp_valid=0: no effect.
- Results never reorder within a requester, since each slot holds one entry.

## Test plan
- Reset, N=8: hold rst 2 cycles with req_valid=11 → req_ready=00 and rsp_valid=00 throughout. First cycle after release → req_ready=01.
- Single add, N=8: r0 ctrl=0000, A=0xFF, B=0x01, cin=1, rsp_ready=11 → next cycle rsp_valid=01, res0=0x01, cout0=1, cmp0=0.
- Contention: both valid every cycle, rsp_ready=11; r1 slt A=0x80 B=0x01, r0 sltu A=0x80 B=0x01 → grants alternate 01,10,01,… Every r1 response has cmp=1, res=0; every r0 response has cmp=0.
- Backpressure: slot0 full with rsp_ready[0]=0, r0 and r1 valid → req_ready=10, r1 served every cycle. Raise rsp_ready[0] → r0 granted that cycle, rsp_valid[0] stays 1 with new data.
- Shifts, N=8: sra A=0x90 B=2 → 0xE4; srl A=0x90 B=9 → 0x00; sll A=0x81 B=1 → 0x02, cout=0.
- Reset mid-op: slot0 full, rst pulse 1 cycle → rsp_valid=00 next cycle, rr_ptr=0. The next contended grant goes to r0.
